bus_arbiter: RTL and testbench

Shares the single system bus between up to eight bus masters, such as the camera grabber, the CPU data port and DMA engines. It collects `requestBus` lines, issues one-hot grants using masked round-robin priority, and tracks each transaction by monitoring the shared `beginTransaction`/`endTransaction` lines. It also cleans up after masters that stall: a granted master that never starts is revoked, and an overlong transaction is terminated with a bus error. It sits between the masters' `requestBus`/`busGrant` pins and the shared bus.

---
 rtl/bus_arbiter_pkg.sv | 31 +++
 rtl/bus_arbiter_round_robin_select.sv | 37 +++
 rtl/bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_bus_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the system bus arbiter.
//   MAX_MASTERS : widest supported requester vector
//   TIMER_W     : width of the shared grant/busy timer
//   arb_state_t : arbiter FSM state encoding
//   clog2       : constant ceiling-log2 helper for parameter checks
package bus_arbiter_pkg;

    localparam int MAX_MASTERS = 8;
    localparam int TIMER_W     = 11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_BUSY    = 3'd2,
        ST_ABORT1  = 3'd3,
        ST_ABORT2  = 3'd4,
        ST_RELEASE = 3'd5
    } arb_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bus_arbiter_round_robin_select.sv
// Combinational round-robin picker.
//   requests : request vector, bits at or above NR_OF_MASTERS must be zero
//   last_id  : index of the previously granted master
//   valid    : at least one request present
//   winner   : first requester scanning upward from last_id+1, wrapping
module round_robin_select
    import bus_arbiter_pkg::*;
#(
    parameter int NR_OF_MASTERS = 4
) (
    input  logic [MAX_MASTERS-1:0] requests,
    input  logic [2:0]             last_id,
    output logic                   valid,
    output logic [2:0]             winner
);

    logic [3:0] idx;

    // Walk candidates from lowest to highest priority so the last hit,
    // i.e. the one nearest last_id+1, is the one that sticks.
    always_comb begin
        idx    = '0;
        winner = last_id;
        for (int k = NR_OF_MASTERS; k >= 1; k--) begin
            idx = {1'b0, last_id} + 4'(k);
            if (idx >= 4'(NR_OF_MASTERS)) begin
                idx = idx - 4'(NR_OF_MASTERS);
            end
            if (requests[idx[2:0]]) begin
                winner = idx[2:0];
            end
        end
    end

    assign valid = |requests;

endmodule

// File: rtl/bus_arbiter.sv
// Shared system bus arbiter with masked round-robin priority and stall cleanup.
//   clock, reset        : system clock, asynchronous active-low reset
//   requests            : requestBus line of each master
//   beginTransactionIn  : shared bus begin strobe
//   endTransactionIn    : shared bus end strobe
//   busErrorIn          : bus error from the slaves
//   grants              : registered one-hot (or zero) busGrant vector
//   grantedId           : index of the current or last granted master
//   busErrorOut         : one-cycle error pulse on busy timeout
//   endTransactionOut   : one-cycle end pulse following busErrorOut
//
// state      | meaning
// -----------+---------------------------------------------
// ST_IDLE    | no grant, arbitrate on any request
// ST_GRANT   | grant issued, waiting for begin
// ST_BUSY    | transaction in flight
// ST_ABORT1  | busy timeout, drive busErrorOut
// ST_ABORT2  | drive endTransactionOut
// ST_RELEASE | one dead cycle with no grant
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int                     NR_OF_MASTERS      = 4,
    parameter logic [MAX_MASTERS-1:0] HIGH_PRIORITY_MASK = 8'h01,
    parameter int                     GRANT_TIMEOUT      = 16,
    parameter int                     BUSY_TIMEOUT       = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NR_OF_MASTERS-1:0] requests,
    input  logic                     beginTransactionIn,
    input  logic                     endTransactionIn,
    input  logic                     busErrorIn,
    output logic [NR_OF_MASTERS-1:0] grants,
    output logic [2:0]               grantedId,
    output logic                     busErrorOut,
    output logic                     endTransactionOut
);

    if (NR_OF_MASTERS < 2 || NR_OF_MASTERS > MAX_MASTERS) begin : g_bad_masters
        $error("bus_arbiter: NR_OF_MASTERS must be in 2..8");
    end
    if (GRANT_TIMEOUT < 1 || clog2(GRANT_TIMEOUT) > TIMER_W) begin : g_bad_grant_to
        $error("bus_arbiter: GRANT_TIMEOUT does not fit the timer");
    end
    if (BUSY_TIMEOUT < 1 || clog2(BUSY_TIMEOUT) > TIMER_W) begin : g_bad_busy_to
        $error("bus_arbiter: BUSY_TIMEOUT does not fit the timer");
    end

    localparam logic [TIMER_W-1:0] GRANT_LAST = TIMER_W'(GRANT_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] BUSY_LAST  = TIMER_W'(BUSY_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;

    arb_state_t               state, state_next;
    logic [TIMER_W-1:0]       timer;
    logic [MAX_MASTERS-1:0]   req_all, req_high;
    logic                     high_valid, all_valid;
    logic [2:0]               high_winner, all_winner, winner, id_next;
    logic [NR_OF_MASTERS-1:0] grants_next;

    // Unused upper request bits stay zero so they can never win.
    always_comb begin
        req_all                      = '0;
        req_all[NR_OF_MASTERS-1:0]   = requests;
    end

    assign req_high = req_all & HIGH_PRIORITY_MASK;

    round_robin_select #(.NR_OF_MASTERS(NR_OF_MASTERS)) u_rr_high (
        .requests (req_high),
        .last_id  (grantedId),
        .valid    (high_valid),
        .winner   (high_winner)
    );

    round_robin_select #(.NR_OF_MASTERS(NR_OF_MASTERS)) u_rr_all (
        .requests (req_all),
        .last_id  (grantedId),
        .valid    (all_valid),
        .winner   (all_winner)
    );

    assign winner = high_valid ? high_winner : all_winner;

    always_comb begin
        state_next  = state;
        grants_next = grants;
        id_next     = grantedId;
        case (state)
            ST_IDLE: begin
                if (all_valid) begin
                    state_next = ST_GRANT;
                    id_next    = winner;
                    for (int i = 0; i < NR_OF_MASTERS; i++) begin
                        grants_next[i] = (winner == 3'(i));
                    end
                end
            end
            ST_GRANT: begin
                // A request drop here is expected and never revokes the grant.
                if (beginTransactionIn) begin
                    state_next = ST_BUSY;
                end else if (timer == GRANT_LAST) begin
                    state_next  = ST_RELEASE;
                    grants_next = '0;
                end
            end
            ST_BUSY: begin
                if (endTransactionIn || busErrorIn) begin
                    state_next  = ST_RELEASE;
                    grants_next = '0;
                end else if (timer == BUSY_LAST) begin
                    state_next = ST_ABORT1;
                end
            end
            ST_ABORT1: begin
                state_next = ST_ABORT2;
            end
            ST_ABORT2: begin
                state_next  = ST_RELEASE;
                grants_next = '0;
            end
            ST_RELEASE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next  = ST_IDLE;
                grants_next = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state             <= ST_IDLE;
            timer             <= '0;
            grants            <= '0;
            grantedId         <= 3'(NR_OF_MASTERS - 1);
            busErrorOut       <= 1'b0;
            endTransactionOut <= 1'b0;
        end else begin
            state             <= state_next;
            grants            <= grants_next;
            grantedId         <= id_next;
            busErrorOut       <= (state_next == ST_ABORT1);
            endTransactionOut <= (state_next == ST_ABORT2);
            if (state_next != state) begin
                timer <= '0;
            end else if (timer != TIMER_MAX) begin
                timer <= timer + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter with default parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bus_arbiter;

    localparam int         N  = 4;
    localparam logic [7:0] HP = 8'h01;
    localparam int         GT = 16;
    localparam int         BT = 1024;

    logic         clock = 1'b0;
    logic         reset;
    logic [N-1:0] requests;
    logic         begin_in, end_in, err_in;
    logic [N-1:0] grants;
    logic [2:0]   granted_id;
    logic         bus_error_out, end_out;

    int n_checks = 0;
    int n_fail   = 0;
    int last_id;

    always #5 clock = ~clock;

    bus_arbiter dut (
        .clock              (clock),
        .reset              (reset),
        .requests           (requests),
        .beginTransactionIn (begin_in),
        .endTransactionIn   (end_in),
        .busErrorIn         (err_in),
        .grants             (grants),
        .grantedId          (granted_id),
        .busErrorOut        (bus_error_out),
        .endTransactionOut  (end_out)
    );

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference arbitration: restrict to the high-priority class when it is
    // requesting, then take the first requester after the last winner.
    function automatic int pick(input logic [N-1:0] req, input int last);
        logic [N-1:0] cls;
        cls = ((req & HP[N-1:0]) != '0) ? (req & HP[N-1:0]) : req;
        for (int k = 1; k <= N; k++) begin
            if (cls[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int id);
        logic [N-1:0] v;
        v = N'(1);
        return v << id;
    endfunction

    task automatic step();
        @(negedge clock);
    endtask

    // Called with the arbiter idle; the grant must show one edge later.
    task automatic expect_grant(input logic [N-1:0] req, input string tag);
        int w;
        w = pick(req, last_id);
        requests = req;
        step();
        chk_eq({tag, "_grant"}, 32'(grants), 32'(onehot(w)));
        chk_eq({tag, "_id"}, 32'(granted_id), 32'(w));
        last_id  = w;
        requests = req & ~onehot(w);
    endtask

    // mode 0: end strobe, 1: bus error in, 2: both in the same cycle
    task automatic run_normal(input int delay, input int len, input int mode, input string tag);
        for (int i = 0; i < delay; i++) begin
            step();
            chk_eq({tag, "_hold_wait"}, 32'(grants), 32'(onehot(last_id)));
        end
        begin_in = 1'b1;
        step();
        begin_in = 1'b0;
        for (int i = 0; i < len; i++) begin
            chk_eq({tag, "_hold_busy"}, 32'(grants), 32'(onehot(last_id)));
            chk_eq({tag, "_no_err"}, 32'(bus_error_out), 32'(0));
            step();
        end
        end_in = (mode != 1);
        err_in = (mode != 0);
        step();
        end_in = 1'b0;
        err_in = 1'b0;
        chk_eq({tag, "_released"}, 32'(grants), 32'(0));
        chk_eq({tag, "_rel_err"}, 32'(bus_error_out), 32'(0));
        chk_eq({tag, "_rel_end"}, 32'(end_out), 32'(0));
        step();
        chk_eq({tag, "_gap"}, 32'(grants), 32'(0));
        chk_eq({tag, "_gap_end"}, 32'(end_out), 32'(0));
    endtask

    task automatic run_timeout(input string tag);
        for (int i = 1; i < GT; i++) begin
            step();
            chk_eq({tag, "_hold"}, 32'(grants), 32'(onehot(last_id)));
        end
        step();
        chk_eq({tag, "_revoked"}, 32'(grants), 32'(0));
        step();
        chk_eq({tag, "_gap"}, 32'(grants), 32'(0));
    endtask

    task automatic run_abort(input string tag);
        begin_in = 1'b1;
        step();
        begin_in = 1'b0;
        for (int i = 0; i < BT; i++) begin
            chk_eq({tag, "_early_err"}, 32'(bus_error_out), 32'(0));
            chk_eq({tag, "_hold"}, 32'(grants), 32'(onehot(last_id)));
            step();
        end
        chk_eq({tag, "_err_pulse"}, 32'(bus_error_out), 32'(1));
        chk_eq({tag, "_err_no_end"}, 32'(end_out), 32'(0));
        chk_eq({tag, "_err_hold"}, 32'(grants), 32'(onehot(last_id)));
        step();
        chk_eq({tag, "_end_pulse"}, 32'(end_out), 32'(1));
        chk_eq({tag, "_err_cleared"}, 32'(bus_error_out), 32'(0));
        chk_eq({tag, "_end_hold"}, 32'(grants), 32'(onehot(last_id)));
        step();
        chk_eq({tag, "_dropped"}, 32'(grants), 32'(0));
        chk_eq({tag, "_end_cleared"}, 32'(end_out), 32'(0));
        step();
    endtask

    initial begin
        logic [N-1:0] r;
        reset    = 1'b0;
        requests = '0;
        begin_in = 1'b0;
        end_in   = 1'b0;
        err_in   = 1'b0;
        last_id  = N - 1;
        repeat (3) step();
        chk_eq("rst_grants", 32'(grants), 32'(0));
        chk_eq("rst_id", 32'(granted_id), 32'(N - 1));
        chk_eq("rst_err", 32'(bus_error_out), 32'(0));
        chk_eq("rst_end", 32'(end_out), 32'(0));
        reset = 1'b1;
        step();

        expect_grant(4'b0110, "first");
        run_normal(1, 2, 0, "first");
        expect_grant(4'b0100, "second");
        run_normal(0, 3, 0, "second");
        expect_grant(4'b1111, "hiprio");
        run_normal(2, 1, 1, "hiprio");
        expect_grant(4'b1110, "after_hi");
        run_normal(3, 0, 0, "after_hi");
        expect_grant(4'b0100, "stall");
        run_timeout("stall");
        expect_grant(4'b1000, "post_stall");
        run_normal(0, 1, 2, "both");
        expect_grant(4'b0010, "abort");
        run_abort("abort");

        for (int it = 0; it < 40; it++) begin
            r = N'($urandom_range(1, (1 << N) - 1));
            if ($urandom_range(0, 3) != 0) r[0] = 1'b0;
            if (r == '0) r = N'(6);
            expect_grant(r, "rnd");
            if ($urandom_range(0, 7) == 0) begin
                run_timeout("rnd_to");
            end else begin
                run_normal($urandom_range(0, 5), $urandom_range(0, 8), $urandom_range(0, 2), "rnd");
            end
        end

        expect_grant(4'b0100, "mid_rst");
        begin_in = 1'b1;
        step();
        begin_in = 1'b0;
        requests = '0;
        repeat (2) step();
        #2 reset = 1'b0;
        #1;
        chk_eq("async_rst_grants", 32'(grants), 32'(0));
        chk_eq("async_rst_id", 32'(granted_id), 32'(N - 1));
        chk_eq("async_rst_err", 32'(bus_error_out), 32'(0));
        chk_eq("async_rst_end", 32'(end_out), 32'(0));
        step();
        reset   = 1'b1;
        last_id = N - 1;
        step();
        expect_grant(4'b0110, "post_rst");
        run_normal(0, 2, 0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
